decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate/output data width; legal values 32 or 64.
REQ-002 Parameter ILEN, default 32, instruction width; fixed at 32 for this generation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 flush  input  1  discards all held instructions.
REQ-006 in_valid  input  1  in_instr carries an instruction.
REQ-007 in_instr  input  ILEN  raw instruction word.
REQ-008 in_ready  output  1  stage accepts an instruction this cycle.
REQ-009 out_valid  output  1  decoded fields are valid.
REQ-010 out_ready  input  1  consumer accepts the decoded fields.
REQ-011 out_fmt  output  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 none.
REQ-012 out_opcode  output  7  instr[6:0].
REQ-013 out_rd, out_rs1, out_rs2  output  5 each  register indices.
REQ-014 out_func3  output  3; out_func7  output  7.
REQ-015 out_imm  output  XLEN  sign-extended immediate.
REQ-016 out_illegal  output  1  unrecognised opcode or malformed instruction.

Function
REQ-017 Decode SHALL be registered: an instruction accepted in cycle N SHALL appear on out_* no earlier than cycle N+1.
REQ-018 Transfer SHALL occur on an input when in_valid and in_ready are both high, and on an output when out_valid and out_ready are both high.
REQ-019 Storage SHALL be one output register plus one skid register, so capacity is two instructions.
REQ-020 in_ready SHALL be a registered signal, equal to the inverse of skid-register occupancy.
REQ-021 Acceptance while the output register is full and out_ready is low SHALL place the instruction in the skid register.
REQ-022 The skid register SHALL move to the output register on the cycle the output transfers.
REQ-023 Simultaneous input and output transfer with the skid register empty SHALL load the output register directly, with no bubble.
REQ-024 out_* fields SHALL hold stable while out_valid is high and out_ready is low.
REQ-025 Opcode-to-format map SHALL be:
- 0110011 -> R
- 0010011, 0000011, 1100111, 1110011 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- all other opcodes -> none.
REQ-026 Field extraction SHALL be: rd = instr[11:7], func3 = [14:12], rs1 = [19:15], rs2 = [24:20], func7 = [31:25].
REQ-027 Any field not defined for the decoded format SHALL be driven to 0.
REQ-028 Immediates SHALL be sign-extended from instr[31] to XLEN:
- I: [31:20]
- S: {[31:25],[11:7]}
- B: {[31],[7],[30:25],[11:8],0}
- U: {[31:12],12'b0}
- J: {[31],[19:12],[20],[30:21],0}
- R and none: 0.
REQ-029 flush SHALL, on the next edge, clear both registers, drive out_valid to 0 and in_ready to 1.
REQ-030 An input handshake in the same cycle as flush SHALL be dropped.
REQ-031 Without illegal checking, out_illegal SHALL be 1 only for format none.

Reset
REQ-032 While rst_n is low at a clock edge, out_valid and skid occupancy SHALL be cleared to 0 and in_ready SHALL be set to 1.
REQ-033 During reset, all out_* data fields SHALL be 0.
REQ-034 Reset mid-transfer SHALL discard held instructions without producing an output handshake.
REQ-035 Reset SHALL take priority over flush.

Configuration
REQ-036 Macro DECODE_ILLEGAL_CHK_EN SHALL enable strict legality checking.
REQ-037 With DECODE_ILLEGAL_CHK_EN defined, out_illegal SHALL additionally be set for:
- instr[1:0] != 2'b11
- R-type with func7 not 0000000 or 0100000
- JALR with func3 != 0
- branch with func3 of 010 or 011
- store with func3 > 010 when XLEN = 32, or > 011 when XLEN = 64.
REQ-038 With DECODE_ILLEGAL_CHK_EN undefined, only REQ-031 applies and no checking logic SHALL be present.

Verification
REQ-039 Reset then addi x1,x2,-1 (0xFFF10093) with out_ready = 1 -> next cycle out_fmt = 1, rd = 1, rs1 = 2, imm = 0xFFFFFFFF, out_illegal = 0.
REQ-040 XLEN = 64, sw x5,-4(x6) (0xFE532E23) -> out_fmt = 2, rs1 = 6, rs2 = 5, rd = 0, imm = 0xFFFFFFFFFFFFFFFC.
REQ-041 out_ready held low, three back-to-back valid instructions -> first two held in order, in_ready low on cycle 2, third accepted only after two output handshakes.
REQ-042 Skid register full, flush asserted with in_valid high -> next cycle out_valid = 0, in_ready = 1, dropped instruction never appears on output.
REQ-043 Opcode 0x0000007F -> out_fmt = 7, out_illegal = 1; with DECODE_ILLEGAL_CHK_EN, 0x40001033 (func7 = 0x20, funct3 001) decodes without illegal and 0x02000033 flags illegal.
REQ-044 Continuous input with out_ready = 1 -> one output per cycle, no bubbles, in_ready never deasserts.

Source files
------------

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if -- handshake and decoded-field bundle for decode_stage.
//
// Purpose: carries the instruction input handshake, the flush request and the
// decoded output handshake between a producer/consumer environment and the
// decode stage.
//
// Signals:
//   flush        discard every instruction held by the stage
//   in_valid     in_instr carries an instruction
//   in_instr     raw instruction word (ILEN bits)
//   in_ready     stage accepts an instruction this cycle
//   out_valid    decoded fields are valid
//   out_ready    consumer accepts the decoded fields
//   out_fmt      0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 none
//   out_opcode   instr[6:0]
//   out_rd/rs1/rs2, out_func3, out_func7   register indices and function codes
//   out_imm      sign-extended immediate (XLEN bits)
//   out_illegal  unrecognised opcode or malformed instruction
//
// Modports: master = environment side, slave = decode stage side.
// -----------------------------------------------------------------------------
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            flush;
  logic            in_valid;
  logic [ILEN-1:0] in_instr;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_fmt;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_fmt, out_opcode, out_rd, out_rs1, out_rs2,
           out_func3, out_func7, out_imm, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_fmt, out_opcode, out_rd, out_rs1, out_rs2,
           out_func3, out_func7, out_imm, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage -- registered RV32/RV64 base-format instruction decoder with a
// two-entry (output register + skid register) elastic buffer.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    decode_stage_if.slave: flush, input handshake (in_valid, in_instr,
//          in_ready) and output handshake with decoded fields (out_*)
//
// Parameters: XLEN (32 or 64) immediate width, ILEN (32) instruction width.
//
// Build option: define DECODE_ILLEGAL_CHK_EN to add strict legality checks
// (low bits, R-type func7, JALR/branch func3, store width). Without it,
// out_illegal flags only opcodes outside the known format map.
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave bus
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  // Pure combinational decode; fields not defined by the format stay zero.
  function automatic dec_t decode(input logic [ILEN-1:0] instr);
    dec_t        d;
    logic [31:0] imm32;
    d        = {$bits(dec_t){1'b0}};
    imm32    = 32'h0000_0000;
    d.opcode = instr[6:0];
    case (instr[6:0])
      OP_OP: begin
        d.fmt   = FMT_R;
        d.rd    = instr[11:7];
        d.func3 = instr[14:12];
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        d.func7 = instr[31:25];
      end
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        d.fmt   = FMT_I;
        d.rd    = instr[11:7];
        d.func3 = instr[14:12];
        d.rs1   = instr[19:15];
        imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        d.fmt   = FMT_S;
        d.func3 = instr[14:12];
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        d.fmt   = FMT_B;
        d.func3 = instr[14:12];
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        d.fmt = FMT_U;
        d.rd  = instr[11:7];
        imm32 = {instr[31:12], 12'h000};
      end
      OP_JAL: begin
        d.fmt = FMT_J;
        d.rd  = instr[11:7];
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        d.fmt = FMT_NONE;
      end
    endcase
    // All immediates fit in 32 bits; widen by sign extension for RV64.
    d.imm = XLEN'($signed(imm32));
`ifdef DECODE_ILLEGAL_CHK_EN
    d.illegal = (d.fmt == FMT_NONE)
             || (instr[1:0] != 2'b11)
             || ((instr[6:0] == OP_OP) && (instr[31:25] != 7'b0000000)
                                       && (instr[31:25] != 7'b0100000))
             || ((instr[6:0] == OP_JALR) && (instr[14:12] != 3'b000))
             || ((instr[6:0] == OP_BRANCH) && ((instr[14:12] == 3'b010) ||
                                               (instr[14:12] == 3'b011)))
             || ((instr[6:0] == OP_STORE) &&
                 (instr[14:12] > ((XLEN == 64) ? 3'b011 : 3'b010)));
`else
    d.illegal = (d.fmt == FMT_NONE);
`endif
    return d;
  endfunction

  logic            out_valid_r;
  dec_t            out_data_r;
  logic            skid_valid_r;
  logic [ILEN-1:0] skid_instr_r;
  logic            in_ready_r;

  logic            in_fire_s;
  logic            out_fire_s;
  logic            out_free_s;
  logic [ILEN-1:0] load_instr_s;
  dec_t            load_dec_s;
  logic            out_valid_n_s;
  dec_t            out_data_n_s;
  logic            skid_valid_n_s;
  logic [ILEN-1:0] skid_instr_n_s;

  // Handshake qualification, decode of the next output-register candidate and next state.
  always_comb begin
    // An input handshake coincident with flush is dropped.
    in_fire_s  = bus.in_valid & in_ready_r & ~bus.flush;
    out_fire_s = out_valid_r & bus.out_ready;
    // Output register can take new content: empty, or draining this edge.
    out_free_s = ~out_valid_r | out_fire_s;
    // Skid content is older than anything on the input, so it goes first.
    load_instr_s = skid_valid_r ? skid_instr_r : bus.in_instr;
    load_dec_s   = decode(load_instr_s);

    out_valid_n_s  = out_valid_r;
    out_data_n_s   = out_data_r;
    skid_valid_n_s = skid_valid_r;
    skid_instr_n_s = skid_instr_r;

    if (bus.flush) begin
      out_valid_n_s  = 1'b0;
      out_data_n_s   = {$bits(dec_t){1'b0}};
      skid_valid_n_s = 1'b0;
      skid_instr_n_s = {ILEN{1'b0}};
    end else if (out_free_s) begin
      // in_ready is low whenever skid is full, so at most one source is live here.
      if (skid_valid_r || in_fire_s) begin
        out_valid_n_s = 1'b1;
        out_data_n_s  = load_dec_s;
      end else begin
        out_valid_n_s = 1'b0;
      end
      skid_valid_n_s = 1'b0;
    end else if (in_fire_s) begin
      // Output stalled: park the new instruction undecoded in the skid slot.
      skid_valid_n_s = 1'b1;
      skid_instr_n_s = bus.in_instr;
    end else begin
      skid_valid_n_s = skid_valid_r;
    end
  end

  // Pipeline state; in_ready is registered from the next skid occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= {$bits(dec_t){1'b0}};
      skid_valid_r <= 1'b0;
      skid_instr_r <= {ILEN{1'b0}};
      in_ready_r   <= 1'b1;
    end else begin
      out_valid_r  <= out_valid_n_s;
      out_data_r   <= out_data_n_s;
      skid_valid_r <= skid_valid_n_s;
      skid_instr_r <= skid_instr_n_s;
      in_ready_r   <= ~skid_valid_n_s;
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_fmt     = out_data_r.fmt;
  assign bus.out_opcode  = out_data_r.opcode;
  assign bus.out_rd      = out_data_r.rd;
  assign bus.out_rs1     = out_data_r.rs1;
  assign bus.out_rs2     = out_data_r.rs2;
  assign bus.out_func3   = out_data_r.func3;
  assign bus.out_func7   = out_data_r.func7;
  assign bus.out_imm     = out_data_r.imm;
  assign bus.out_illegal = out_data_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage -- directed self-checking bench for decode_stage.
// Drives an XLEN=32 instance through reset, single decode, skid fill/drain,
// flush, mid-transfer reset and a continuous stream of hand-decoded
// instructions, plus an XLEN=64 instance for 64-bit sign extension.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  decode_stage_if #(.XLEN(32), .ILEN(32)) bus ();
  decode_stage_if #(.XLEN(64), .ILEN(32)) bus64 ();

  decode_stage #(.XLEN(32), .ILEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  decode_stage #(.XLEN(64), .ILEN(32)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        ill_def;
    logic        ill_strict;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_ill;
    n_cmp = 0;
    n_mis = 0;

    tbl[0]  = '{32'h123452B7, 3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFFFF317, 3'd4, 5'd6, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 1'b0, 1'b0};
    tbl[2]  = '{32'hFFDFF0EF, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0, 1'b0};
    tbl[3]  = '{32'h00208463, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000008, 1'b0, 1'b0};
    tbl[4]  = '{32'hFE001FE3, 3'd3, 5'd0, 5'd0, 5'd0, 3'd1, 7'h00, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[5]  = '{32'h7FF42383, 3'd1, 5'd7, 5'd8, 5'd0, 3'd2, 7'h00, 32'h000007FF, 1'b0, 1'b0};
    tbl[6]  = '{32'h00008067, 3'd1, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b0};
    tbl[7]  = '{32'h00009067, 3'd1, 5'd0, 5'd1, 5'd0, 3'd1, 7'h00, 32'h00000000, 1'b0, 1'b1};
    tbl[8]  = '{32'h00002063, 3'd3, 5'd0, 5'd0, 5'd0, 3'd2, 7'h00, 32'h00000000, 1'b0, 1'b1};
    tbl[9]  = '{32'h00003023, 3'd2, 5'd0, 5'd0, 5'd0, 3'd3, 7'h00, 32'h00000000, 1'b0, 1'b1};
    tbl[10] = '{32'h402081B3, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 1'b0, 1'b0};
    tbl[11] = '{32'h40001033, 3'd0, 5'd0, 5'd0, 5'd0, 3'd1, 7'h20, 32'h00000000, 1'b0, 1'b0};
    tbl[12] = '{32'h02000033, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h01, 32'h00000000, 1'b0, 1'b1};
    tbl[13] = '{32'h0000007F, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1, 1'b1};
    tbl[14] = '{32'h00000001, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1, 1'b1};

    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_instr   = 32'hFFF10093;
    bus.out_ready  = 1'b0;
    bus64.flush    = 1'b0;
    bus64.in_valid = 1'b0;
    bus64.in_instr = 32'h0;
    bus64.out_ready = 1'b0;

    // Reset state (input offered during reset must not be taken)
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 64'd0);
    chk("rst_in_ready", bus.in_ready, 64'd1);
    chk("rst_fmt", bus.out_fmt, 64'd0);
    chk("rst_rd", bus.out_rd, 64'd0);
    chk("rst_imm", bus.out_imm, 64'd0);
    chk("rst_illegal", bus.out_illegal, 64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_out_valid", bus.out_valid, 64'd0);

    // addi x1,x2,-1
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'hFFF10093;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("addi_valid", bus.out_valid, 64'd1);
    chk("addi_fmt", bus.out_fmt, 64'd1);
    chk("addi_opcode", bus.out_opcode, 64'h13);
    chk("addi_rd", bus.out_rd, 64'd1);
    chk("addi_rs1", bus.out_rs1, 64'd2);
    chk("addi_rs2", bus.out_rs2, 64'd0);
    chk("addi_func7", bus.out_func7, 64'd0);
    chk("addi_imm", bus.out_imm, 64'hFFFFFFFF);
    chk("addi_illegal", bus.out_illegal, 64'd0);
    step();
    chk("addi_drained", bus.out_valid, 64'd0);

    // XLEN=64: sw x5,-4(x6), then auipc for U sign extension
    bus64.in_valid  = 1'b1;
    bus64.in_instr  = 32'hFE532E23;
    bus64.out_ready = 1'b1;
    step();
    bus64.in_instr = 32'hFFFFF317;
    chk("sw64_valid", bus64.out_valid, 64'd1);
    chk("sw64_fmt", bus64.out_fmt, 64'd2);
    chk("sw64_rs1", bus64.out_rs1, 64'd6);
    chk("sw64_rs2", bus64.out_rs2, 64'd5);
    chk("sw64_rd", bus64.out_rd, 64'd0);
    chk("sw64_func3", bus64.out_func3, 64'd2);
    chk("sw64_imm", bus64.out_imm, 64'hFFFFFFFFFFFFFFFC);
    step();
    bus64.in_valid = 1'b0;
    chk("auipc64_imm", bus64.out_imm, 64'hFFFFFFFFFFFFF000);
    chk("auipc64_rd", bus64.out_rd, 64'd6);
    step();
    chk("auipc64_drained", bus64.out_valid, 64'd0);

    // Skid: three back-to-back with out_ready low
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00500093;  // addi x1,x0,5
    chk("skid_ready0", bus.in_ready, 64'd1);
    step();
    chk("skid_a_valid", bus.out_valid, 64'd1);
    chk("skid_a_rd", bus.out_rd, 64'd1);
    chk("skid_ready1", bus.in_ready, 64'd1);
    bus.in_instr = 32'h00A00113;  // addi x2,x0,10
    step();
    chk("skid_ready2", bus.in_ready, 64'd0);
    chk("skid_a_hold_rd", bus.out_rd, 64'd1);
    chk("skid_a_hold_imm", bus.out_imm, 64'd5);
    bus.in_instr = 32'h00F00193;  // addi x3,x0,15
    step();
    chk("skid_ready3", bus.in_ready, 64'd0);
    chk("skid_a_stable_rd", bus.out_rd, 64'd1);
    chk("skid_a_stable_valid", bus.out_valid, 64'd1);
    bus.out_ready = 1'b1;
    step();
    chk("skid_b_rd", bus.out_rd, 64'd2);
    chk("skid_b_imm", bus.out_imm, 64'd10);
    chk("skid_b_valid", bus.out_valid, 64'd1);
    chk("skid_ready4", bus.in_ready, 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("skid_c_rd", bus.out_rd, 64'd3);
    chk("skid_c_imm", bus.out_imm, 64'd15);
    chk("skid_c_valid", bus.out_valid, 64'd1);
    step();
    chk("skid_drained", bus.out_valid, 64'd0);

    // Flush with skid full and an input offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00500093;
    step();
    bus.in_instr = 32'h00A00113;
    step();
    chk("flush_pre_ready", bus.in_ready, 64'd0);
    bus.flush    = 1'b1;
    bus.in_instr = 32'h01400213;  // addi x4,x0,20
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", bus.out_valid, 64'd0);
    chk("flush_in_ready", bus.in_ready, 64'd1);
    bus.out_ready = 1'b1;
    step();
    chk("flush_nothing_out", bus.out_valid, 64'd0);
    // Flush coincident with a live input handshake drops it
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_drop_valid", bus.out_valid, 64'd0);
    step();
    chk("flush_drop_later", bus.out_valid, 64'd0);

    // Reset while both registers are occupied
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00500093;
    step();
    bus.in_instr = 32'h00A00113;
    step();
    chk("rstmid_pre_ready", bus.in_ready, 64'd0);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("rstmid_out_valid", bus.out_valid, 64'd0);
    chk("rstmid_in_ready", bus.in_ready, 64'd1);
    chk("rstmid_rd", bus.out_rd, 64'd0);
    chk("rstmid_imm", bus.out_imm, 64'd0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("rstmid_nothing_out", bus.out_valid, 64'd0);

    // Continuous stream, out_ready high: one decoded output per cycle
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.in_instr = tbl[i].instr;
      step();
`ifdef DECODE_ILLEGAL_CHK_EN
      exp_ill = tbl[i].ill_strict;
`else
      exp_ill = tbl[i].ill_def;
`endif
      chk($sformatf("strm%0d_valid", i), bus.out_valid, 64'd1);
      chk($sformatf("strm%0d_in_ready", i), bus.in_ready, 64'd1);
      chk($sformatf("strm%0d_opcode", i), bus.out_opcode, {57'd0, tbl[i].instr[6:0]});
      chk($sformatf("strm%0d_fmt", i), bus.out_fmt, {61'd0, tbl[i].fmt});
      chk($sformatf("strm%0d_rd", i), bus.out_rd, {59'd0, tbl[i].rd});
      chk($sformatf("strm%0d_rs1", i), bus.out_rs1, {59'd0, tbl[i].rs1});
      chk($sformatf("strm%0d_rs2", i), bus.out_rs2, {59'd0, tbl[i].rs2});
      chk($sformatf("strm%0d_func3", i), bus.out_func3, {61'd0, tbl[i].func3});
      chk($sformatf("strm%0d_func7", i), bus.out_func7, {57'd0, tbl[i].func7});
      chk($sformatf("strm%0d_imm", i), bus.out_imm, {32'd0, tbl[i].imm});
      chk($sformatf("strm%0d_illegal", i), bus.out_illegal, {63'd0, exp_ill});
    end
    bus.in_valid = 1'b0;
    step();
    chk("strm_drained", bus.out_valid, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
